// File: rtl/mme_operand_fetch.sv
// mme_operand_fetch
//   AXI read master feeding the MME compute core. For each reduction index
//   k = 0 .. mat_width-1 it reads column k of A (4 words, column-major) and
//   row k of B (4 words, row-major), then presents the pair as one operand
//   vector on a valid/ready handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start
//   AR_A   | A burst request on AR, held until arready
//   R_A    | collecting 4 A beats into a_vec lanes 0..3
//   AR_B   | B burst request on AR, held until arready
//   R_B    | collecting 4 B beats into b_vec lanes 0..3
//   OUT    | operand pair offered to the core, held until vec_ready
//   FIN    | one-cycle done pulse, then back to IDLE
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   start, mat_width, a_addr,
//   b_addr                       control/config (sampled on accepted start)
//   busy, done, err              status (err sticky until next start)
//   ar*                          AXI read address channel (4-beat INCR bursts)
//   r*                           AXI read data channel
//   a_vec, b_vec, vec_valid,
//   vec_last, vec_ready          operand vector handshake to the core

module mme_operand_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         mat_width,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [ADDR_W-1:0]   b_addr,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [4*DATA_W-1:0] a_vec,
  output logic [4*DATA_W-1:0] b_vec,
  output logic                vec_valid,
  output logic                vec_last,
  input  logic                vec_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR_A, S_R_A, S_AR_B, S_R_B, S_OUT, S_FIN
  } state_t;

  state_t            state;
  logic [31:0]       k;
  logic [31:0]       width_q;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [1:0]        beat;

  logic [ADDR_W-1:0] k_off;
  logic [ADDR_W-1:0] k_off_nxt;
  logic [31:0]       k_nxt;
  logic              beat_err;

  // Each k advances 16 bytes; the sum wraps naturally at ADDR_W bits.
  assign k_nxt     = k + 32'd1;
  assign k_off     = ADDR_W'(k) << 4;
  assign k_off_nxt = ADDR_W'(k_nxt) << 4;

  // rlast is only checked, never trusted: the beat counter ends the burst.
  assign beat_err = (rresp != 2'b00) || (rlast != (beat == 2'd3));

  assign arid    = '0;
  assign arlen   = 8'd3;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  logic unused_ok;
  assign unused_ok = ^{rid, a_addr[3:0], b_addr[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= '0;
      width_q   <= '0;
      a_base    <= '0;
      b_base    <= '0;
      beat      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      a_vec     <= '0;
      b_vec     <= '0;
      vec_valid <= 1'b0;
      vec_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            width_q <= mat_width;
            a_base  <= {a_addr[ADDR_W-1:4], 4'b0000};
            b_base  <= {b_addr[ADDR_W-1:4], 4'b0000};
            err     <= 1'b0;
            k       <= '0;
            if (mat_width == 32'd0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              busy    <= 1'b1;
              arvalid <= 1'b1;
              araddr  <= {a_addr[ADDR_W-1:4], 4'b0000};
              state   <= S_AR_A;
            end
          end
        end

        S_AR_A: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat    <= '0;
            state   <= S_R_A;
          end
        end

        S_R_A: begin
          if (rvalid) begin
            a_vec[int'(beat)*DATA_W +: DATA_W] <= rdata;
            if (beat_err) err <= 1'b1;
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              rready  <= 1'b0;
              arvalid <= 1'b1;
              araddr  <= b_base + k_off;
              state   <= S_AR_B;
            end
          end
        end

        S_AR_B: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            beat    <= '0;
            state   <= S_R_B;
          end
        end

        S_R_B: begin
          if (rvalid) begin
            b_vec[int'(beat)*DATA_W +: DATA_W] <= rdata;
            if (beat_err) err <= 1'b1;
            beat <= beat + 2'd1;
            if (beat == 2'd3) begin
              rready    <= 1'b0;
              vec_valid <= 1'b1;
              vec_last  <= (k == width_q - 32'd1);
              state     <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (vec_ready) begin
            vec_valid <= 1'b0;
            vec_last  <= 1'b0;
            if (vec_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end else begin
              k       <= k_nxt;
              arvalid <= 1'b1;
              araddr  <= a_base + k_off_nxt;
              state   <= S_AR_A;
            end
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mme_operand_fetch.sv
// tb_mme_operand_fetch
//   Bench for mme_operand_fetch. A behavioural AXI slave answers bursts from a
//   hashed memory image; expected AR addresses and operand vectors are queued
//   when a run is started and popped as the DUT produces them.

module tb_mme_operand_fetch;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [31:0]       mat_width;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              busy, done, err;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid, arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic [127:0]      a_vec, b_vec;
  logic              vec_valid, vec_last, vec_ready;

  always #5 clk = ~clk;

  mme_operand_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_width(mat_width),
    .a_addr(a_addr), .b_addr(b_addr), .busy(busy), .done(done), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .a_vec(a_vec), .b_vec(b_vec), .vec_valid(vec_valid),
    .vec_last(vec_last), .vec_ready(vec_ready)
  );

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    bit          rnd;
    bit          stall;
    bit          slverr;
    bit          bad_rlast;
    bit          exp_err;
  } case_t;

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    bit           last;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] arq[$];

  int checks   = 0;
  int failures = 0;

  bit          rnd_mode, stall_mode, slverr_en, bad_rlast_en;
  logic [31:0] slverr_addr;
  bit          burst_active, ar_will, r_will;
  logic [31:0] burst_addr;
  int          beat, ar_dly, r_dly, ar_count, done_cnt;

  bit           vec_fire, held_valid;
  int           stall_cnt;
  logic [127:0] held_a, held_b;
  logic         held_last;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] addr);
    return (addr * 32'h0100_0193) ^ 32'hA5A5_5A5A;
  endfunction

  function automatic int dly();
    return rnd_mode ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // AXI slave: decisions at negedge, handshakes land on the following posedge.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    burst_active = 1'b0; ar_will = 1'b0; r_will = 1'b0; beat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        burst_active = 1'b0; ar_will = 1'b0; r_will = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        continue;
      end
      if (r_will) begin
        beat++;
        rvalid = 1'b0;
        if (beat == 4) burst_active = 1'b0;
        r_dly = dly();
      end
      ar_will = 1'b0;
      r_will  = 1'b0;
      if (arvalid) chk("one_ar_outstanding", burst_active, 1'b0);
      if (rready)  chk("rready_only_in_burst", burst_active, 1'b1);
      if (burst_active && !rvalid && beat < 4) begin
        if (r_dly > 0) r_dly--;
        else begin
          rvalid = 1'b1;
          rdata  = mem(burst_addr + 32'(4 * beat));
          rlast  = (beat == 3) && !(bad_rlast_en && ar_count == 1);
          rresp  = (slverr_en && burst_addr == slverr_addr && beat == 2) ? 2'b10 : 2'b00;
        end
      end
      if (rvalid && rready) r_will = 1'b1;
      arready = 1'b0;
      if (arvalid && !burst_active) begin
        if (ar_dly > 0) ar_dly--;
        else begin
          arready = 1'b1;
          ar_will = 1'b1;
          burst_active = 1'b1;
          burst_addr = araddr;
          beat = 0;
          ar_count++;
          r_dly = dly();
          ar_dly = dly();
          if (arq.size() == 0) begin
            failures++; checks++;
            $display("FAIL araddr_unexpected actual=%h required=none", araddr);
          end else chk($sformatf("araddr_%0d", ar_count), araddr, arq.pop_front());
        end
      end
    end
  end

  // Core-side consumer and done monitor.
  initial begin
    vec_ready = 1'b0; vec_fire = 1'b0; held_valid = 1'b0; stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vec_ready = 1'b0; vec_fire = 1'b0; held_valid = 1'b0; stall_cnt = 0;
        continue;
      end
      if (vec_fire) begin
        vec_fire = 1'b0; held_valid = 1'b0; stall_cnt = 0;
      end
      if (vec_valid) begin
        if (held_valid) begin
          chk("stall_a_vec_stable", a_vec, held_a);
          chk("stall_b_vec_stable", b_vec, held_b);
          chk("stall_vec_last_stable", vec_last, held_last);
        end
        held_a = a_vec; held_b = b_vec; held_last = vec_last; held_valid = 1'b1;
        vec_ready = stall_mode ? (stall_cnt >= 10) : 1'b1;
        stall_cnt++;
        if (vec_ready) begin
          vec_fire = 1'b1;
          if (vq.size() == 0) begin
            failures++; checks++;
            $display("FAIL vec_unexpected actual=%h required=none", a_vec);
          end else begin
            vec_t e;
            e = vq.pop_front();
            chk("a_vec", a_vec, e.a);
            chk("b_vec", b_vec, e.b);
            chk("vec_last", vec_last, e.last);
          end
        end
      end else begin
        vec_ready = !stall_mode;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_vec", vq.size(), 0);
      end
    end
  end

  task automatic prep(input case_t c);
    logic [31:0] ab, bb;
    vec_t v;
    rnd_mode = c.rnd; stall_mode = c.stall;
    slverr_en = c.slverr; bad_rlast_en = c.bad_rlast;
    vq.delete(); arq.delete();
    ar_count = 0; done_cnt = 0; ar_dly = dly();
    slverr_addr = {c.b[31:4], 4'b0000} + 32'd16;
    for (int k = 0; k < c.w; k++) begin
      ab = {c.a[31:4], 4'b0000} + 32'(16 * k);
      bb = {c.b[31:4], 4'b0000} + 32'(16 * k);
      arq.push_back(ab);
      arq.push_back(bb);
      for (int i = 0; i < 4; i++) begin
        v.a[32*i +: 32] = mem(ab + 32'(4 * i));
        v.b[32*i +: 32] = mem(bb + 32'(4 * i));
      end
      v.last = (k == c.w - 1);
      vq.push_back(v);
    end
  endtask

  task automatic pulse_start(input case_t c);
    @(negedge clk);
    start = 1'b1; mat_width = 32'(c.w); a_addr = c.a; b_addr = c.b;
    @(negedge clk);
    start = 1'b0; mat_width = 32'd7; a_addr = 32'hDEAD_0000; b_addr = 32'hBEEF_0000;
  endtask

  task automatic run_case(input case_t c, input int idx);
    int cyc;
    prep(c);
    pulse_start(c);
    chk($sformatf("c%0d_busy_after_start", idx), busy, 1'b1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 20 && busy) begin
        start = 1'b1; mat_width = 32'd1; a_addr = 32'h0BAD_0000;
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
    end
    chk($sformatf("c%0d_done_seen", idx), done_cnt > 0, 1'b1);
    if (!c.rnd && !c.stall)
      chk($sformatf("c%0d_throughput", idx), cyc <= 13 * c.w + 2, 1'b1);
    repeat (5) @(negedge clk);
    chk($sformatf("c%0d_done_count", idx), done_cnt, 1);
    chk($sformatf("c%0d_err", idx), err, c.exp_err);
    chk($sformatf("c%0d_busy_end", idx), busy, 1'b0);
    chk($sformatf("c%0d_ar_left", idx), arq.size(), 0);
    chk($sformatf("c%0d_vec_left", idx), vq.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ctrl"}, {arvalid, rready, vec_valid, vec_last, busy, done, err}, 7'd0);
    chk({name, "_araddr"}, araddr, 32'd0);
    chk({name, "_a_vec"}, a_vec, 128'd0);
    chk({name, "_b_vec"}, b_vec, 128'd0);
  endtask

  case_t tbl[7];

  initial begin
    case_t c;
    int cyc;
    //          w   a             b             rnd stall slv  rl  err
    tbl[0] = '{ 4, 32'h0000_0000, 32'h0000_1000, 0,  0,  0,  0,  0};
    tbl[1] = '{16, 32'h0000_2000, 32'h0000_3000, 0,  1,  0,  0,  0};
    tbl[2] = '{ 8, 32'h0000_0000, 32'h0000_1000, 1,  0,  0,  0,  0};
    tbl[3] = '{ 4, 32'h0000_0100, 32'h0000_5000, 0,  0,  1,  0,  1};
    tbl[4] = '{ 3, 32'h0000_0040, 32'h0000_0080, 1,  0,  0,  0,  0};
    tbl[5] = '{ 2, 32'hFFFF_FFF8, 32'h1234_5677, 0,  0,  0,  0,  0};
    tbl[6] = '{ 2, 32'h0000_0000, 32'h0000_0000, 0,  0,  0,  1,  1};

    rst_n = 1'b0; start = 1'b0; mat_width = '0; a_addr = '0; b_addr = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_consts", {arid, arlen, arsize, arburst}, {4'd0, 8'd3, 3'b010, 2'b01});
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_case(tbl[i], i);

    // zero width: done right after start, no AR traffic
    c = '{0, 32'h0000_0400, 32'h0000_0800, 0, 0, 0, 0, 0};
    prep(c);
    pulse_start(c);
    chk("w0_done", done, 1'b1);
    chk("w0_no_arvalid", arvalid, 1'b0);
    @(negedge clk);
    chk("w0_done_pulse_end", done, 1'b0);
    repeat (3) @(negedge clk);
    chk("w0_done_count", done_cnt, 1);
    chk("w0_no_ar", ar_count, 0);

    // reset during R_A of k=2
    c = tbl[0];
    prep(c);
    pulse_start(c);
    cyc = 0;
    while (!(ar_count == 5 && rready) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_k2_ra", cyc < 500, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_case(tbl[0], 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
